// File: rtl/lif_neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_pkg
//  Description : Shared fixed-point types, saturation limits and FSM encoding
//                for the leaky integrate-and-fire neuron datapath.
//                Values are Q21.10: signed 32-bit, 10 fractional bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  localparam int FRAC_BITS = 10;
  localparam int FIX_ONE   = 1024;

  typedef logic signed [31:0] q21_10_t;

  localparam q21_10_t SAT_MAX = 32'sh7FFF_FFFF;
  localparam q21_10_t SAT_MIN = 32'sh8000_0000;

  typedef enum logic {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } state_t;

  // Spike counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/lif_neuron_sat_add32.sv
`default_nettype none
// ============================================================================
//  Module      : sat_add32
//  Description : Combinational signed adder. Operands are 33-bit signed so
//                that a negated leak term always fits; the sum is formed in
//                34 bits and clamped to the signed 32-bit range.
//  Ports       : i_a, i_b  - signed 33-bit operands
//                o_sum     - signed 32-bit saturated sum
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_add32
  import neuron_pkg::*;
(
  input  logic signed [32:0] i_a,
  input  logic signed [32:0] i_b,
  output logic signed [31:0] o_sum
);

  localparam logic signed [33:0] c_max = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] c_min = 34'sh3_8000_0000;

  logic signed [33:0] w_sum;

  assign w_sum = {i_a[32], i_a} + {i_b[32], i_b};

  always_comb begin
    o_sum = w_sum[31:0];
    if (w_sum > c_max) begin
      o_sum = SAT_MAX;
    end else if (w_sum < c_min) begin
      o_sum = SAT_MIN;
    end
  end

endmodule : sat_add32
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron
//  Description : Single leaky integrate-and-fire neuron. On each step_en
//                strobe the membrane leaks towards V_REST, integrates I_in,
//                and fires a one-cycle spike when the threshold is reached.
//                A refractory period of REFRACT_STEPS steps follows a spike.
//  Ports       : clk         - simulation clock
//                reset_bar   - asynchronous active-low reset
//                step_en     - one membrane update per cycle it is high
//                I_in        - signed Q21.10 synaptic current
//                v_out       - registered membrane potential (Q21.10)
//                spike_out   - one-cycle spike pulse
//                refractory  - high while in the refractory state
//                spike_count - saturating spike count since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron
  import neuron_pkg::*;
#(
  parameter logic signed [31:0] V_REST        = 32'sd0,
  parameter logic signed [31:0] V_THRESH      = 32'sd20480,
  parameter logic signed [31:0] V_RESET       = 32'sd0,
  parameter int                 LEAK_SHIFT    = 3,
  parameter int                 REFRACT_STEPS = 2
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        step_en,
  input  logic [31:0] I_in,
  output logic [31:0] v_out,
  output logic        spike_out,
  output logic        refractory,
  output logic [15:0] spike_count
);

  localparam logic [7:0] c_refract_steps = 8'(REFRACT_STEPS);
  localparam logic       c_refract_en    = (REFRACT_STEPS != 0);

  state_t             r_state;
  logic signed [31:0] r_v;
  logic               r_spike;
  logic               r_refractory;
  logic [15:0]        r_count;
  logic [7:0]         r_ref_cnt;

  logic signed [32:0] w_diff;
  logic signed [32:0] w_leak;
  logic signed [32:0] w_neg_leak;
  logic signed [31:0] w_v_leaked;
  logic signed [31:0] w_v_next;
  logic signed [31:0] w_i_in;
  logic               w_fire;

  assign w_i_in = I_in;

  // v - V_REST needs 33 bits; after a shift of at least one its magnitude is
  // at most 2^31, so its negation still fits the 33-bit adder operand.
  assign w_diff     = {r_v[31], r_v} - {V_REST[31], V_REST};
  assign w_leak     = w_diff >>> LEAK_SHIFT;
  assign w_neg_leak = -w_leak;

  // v - leak always lies between v and V_REST, so clamping it before the
  // current is added gives the same result as one wide sum clamped once.
  sat_add32 u_leak_sub (
    .i_a   ({r_v[31], r_v}),
    .i_b   (w_neg_leak),
    .o_sum (w_v_leaked)
  );

  sat_add32 u_current_add (
    .i_a   ({w_v_leaked[31], w_v_leaked}),
    .i_b   ({w_i_in[31], w_i_in}),
    .o_sum (w_v_next)
  );

  // Threshold is compared against the already-clamped potential.
  assign w_fire = (w_v_next >= V_THRESH);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state      <= INTEGRATE;
      r_v          <= V_REST;
      r_spike      <= 1'b0;
      r_refractory <= 1'b0;
      r_count      <= 16'd0;
      r_ref_cnt    <= 8'd0;
    end else begin
      // Spike is a pulse: cleared on every cycle that does not fire.
      r_spike <= 1'b0;
      if (step_en) begin
        case (r_state)
          INTEGRATE: begin
            if (w_fire) begin
              r_v     <= V_RESET;
              r_spike <= 1'b1;
              r_count <= sat_inc16(r_count);
              if (c_refract_en) begin
                r_state      <= REFRACT;
                r_ref_cnt    <= c_refract_steps;
                r_refractory <= 1'b1;
              end
            end else begin
              r_v <= w_v_next;
            end
          end
          REFRACT: begin
            // Input is ignored; the step that sees ref_cnt==1 is the last
            // ignored one.
            r_v       <= V_RESET;
            r_ref_cnt <= r_ref_cnt - 8'd1;
            if (r_ref_cnt == 8'd1) begin
              r_state      <= INTEGRATE;
              r_refractory <= 1'b0;
            end
          end
          default: begin
            r_state      <= INTEGRATE;
            r_refractory <= 1'b0;
          end
        endcase
      end
    end
  end

  assign v_out       = r_v;
  assign spike_out   = r_spike;
  assign refractory  = r_refractory;
  assign spike_count = r_count;

endmodule : lif_neuron
`default_nettype wire
